mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MA-stage initiator between the pipeline and the word-only data memory. Converts RV32IM
//  loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-aligned read / write / read-modify-write
//  transactions on the memory's {read,write,address,writedata,readdata,busywait} interface.
//  Stalls the pipeline via cpu_busywait, extracts/sign-extends load data, flags faults.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles mem_busywait may stay high per access; 0 disables timeout
// PORTS
//  clock           in   1   single clock; all state updates on posedge
//  reset           in   1   synchronous, active-high
//  cpu_read        in   4   {en, funct3}; en=1 -> load
//  cpu_write       in   3   {en, funct3[1:0]}; en=1 -> store
//  cpu_address     in   32  byte address
//  cpu_writedata   in   32  store data (low byte/half used for SB/SH)
//  cpu_readdata    out  32  extended load result, valid in DONE
//  cpu_busywait    out  1   stall request to pipeline
//  cpu_fault       out  1   one-cycle pulse in DONE on misalign/illegal/timeout
//  mem_read        out  4   {en, 3'b010}, registered
//  mem_write       out  3   {en, 2'b10}, registered
//  mem_address     out  32  {cpu_address[31:2],2'b00}, registered
//  mem_writedata   out  32  full or merged word, registered
//  mem_readdata    in   32  word from memory
//  mem_busywait    in   1   memory not ready
// BEHAVIOUR
//  Reset (sync): state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_writedata=0,
//   cpu_readdata=0, cpu_fault=0, timeout counter=0. Reset mid-access aborts; enables low next cycle.
//  Byte order little-endian: byte k of word = bits [8k+7:8k], k=address[1:0].
//  FSM: IDLE, RD, WR, DONE.
//   IDLE: cpu_busywait = cpu_read[3]|cpu_write[2] (combinational). On request at posedge:
//    both en set, illegal funct3 (load 011/110/111, store 11), LH/LHU/SH addr[0]!=0,
//    LW/SW addr[1:0]!=0 -> DONE with fault, no memory strobe.
//    load or SB/SH -> RD; SW -> WR with mem_writedata=cpu_writedata.
//   RD: mem_read en=1, cpu_busywait=1. At posedge with mem_busywait=0: latch mem_readdata;
//    load -> DONE with cpu_readdata=extracted value; SB/SH -> WR with merged word
//    (new byte/half replaces lane addr[1:0]/addr[1], other lanes from readdata).
//   WR: mem_write en=1, cpu_busywait=1. At posedge with mem_busywait=0 -> DONE.
//   DONE: cpu_busywait=0, mem enables 0, cpu_fault per latched flag; pipeline advances on this
//    edge; next state IDLE unconditionally (no re-trigger of same request).
//  Extraction: LB/LH sign-extend bit 7/15 of selected lane; LBU/LHU zero-extend; LW whole word.
//  Stores return cpu_readdata=0.
//  Timeout: counter increments each RD/WR cycle with mem_busywait=1, clears on state change;
//   reaching TIMEOUT_CYCLES -> DONE with fault, store not committed.
//  Latency (zero-wait memory): load / SW = 3 cycles request-to-DONE inclusive; SB/SH = 4;
//   each busywait cycle adds 1. Fault = 2 cycles.
//  Pipeline holds cpu_* stable while cpu_busywait=1; unit samples them only in IDLE.
// STRUCTURE
//  Package mau_pkg: funct3 constants (LB..LHU, SB/SH/SW), state enum, MEM_WORD_RD=4'b1010,
//   MEM_WORD_WR=3'b110.
//  Sub-module load_store_align: combinational lane extract/sign-extend and store merge.
// TESTING (memory model word 0x10 = 0x8899AABB, configurable busywait)
//  LB 0x11, zero wait -> cpu_readdata=0xFFFFFFAA in DONE, cpu_busywait high exactly 2 cycles.
//  LHU 0x12 -> 0x00008899; LW 0x10 -> 0x8899AABB; LH 0x12 -> 0xFFFF8899.
//  SB 0x13 data 0x00000055 -> one mem read then one mem write of 0x5599AABB; 4-cycle latency.
//  SW 0x10 0xDEADBEEF, mem_busywait high 5 cycles -> cpu_busywait stays high, DONE on 8th cycle,
//   word reads back 0xDEADBEEF.
//  LW 0x06 / SH 0x11 / load funct3 011 -> cpu_fault pulse, no mem_read/mem_write strobe.
//  reset asserted in RD with mem_busywait=1 -> IDLE next cycle, enables 0; TIMEOUT_CYCLES=4 and
//   busywait stuck -> fault after 4 wait cycles, memory unchanged.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
//   - RV32 load/store funct3 encodings handled by the unit
//   - memory strobe encodings (word read / word write)
//   - FSM state type
//   - req_fault(): decides whether a pipeline request must fault without
//     touching memory (conflicting enables, illegal width, misalignment)
package mau_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F2_SB  = 2'b00;
    localparam logic [1:0] F2_SH  = 2'b01;
    localparam logic [1:0] F2_SW  = 2'b10;

    // {en, funct3=LW} and {en, funct3[1:0]=SW}: the memory only moves words
    localparam logic [3:0] MEM_WORD_RD = 4'b1010;
    localparam logic [2:0] MEM_WORD_WR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } mau_state_e;

    // Returns 1 when the request cannot be issued to memory at all.
    function automatic logic req_fault(input logic [3:0] rd,
                                       input logic [2:0] wr,
                                       input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        if (rd[3] && wr[2]) begin
            f = 1'b1;
        end else if (rd[3]) begin
            case (rd[2:0])
                F3_LB, F3_LBU: f = 1'b0;
                F3_LH, F3_LHU: f = addr_lo[0];
                F3_LW:         f = (addr_lo != 2'b00);
                default:       f = 1'b1;
            endcase
        end else if (wr[2]) begin
            case (wr[1:0])
                F2_SB:   f = 1'b0;
                F2_SH:   f = addr_lo[0];
                F2_SW:   f = (addr_lo != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/mau_if.sv
// Word-only data memory bus.
//   mem_read      {en, 3'b010}  word read strobe
//   mem_write     {en, 2'b10}   word write strobe
//   mem_address   word-aligned byte address
//   mem_writedata word to store
//   mem_readdata  word returned by memory
//   mem_busywait  memory not ready; strobes are held until it drops
// master = access unit (initiator), slave = memory.
interface mau_if;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane handling for sub-word accesses (little-endian).
//   load_funct3   load width/sign selector
//   store_funct2  store width selector
//   byte_offset   address[1:0] of the access
//   word_in       word read from memory
//   store_data    pipeline store data (low byte/half used for SB/SH)
//   load_data     extracted and extended load result
//   merged_word   word_in with the store lane(s) replaced
module load_store_align
    import mau_pkg::*;
(
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  store_funct2,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes
    always_comb begin
        byte_s = 8'h00;
        case (byte_offset)
            2'b00:   byte_s = word_in[7:0];
            2'b01:   byte_s = word_in[15:8];
            2'b10:   byte_s = word_in[23:16];
            2'b11:   byte_s = word_in[31:24];
            default: byte_s = 8'h00;
        endcase
        if (byte_offset[1]) begin
            half_s = word_in[31:16];
        end else begin
            half_s = word_in[15:0];
        end
    end

    // Extend the selected lane according to the load type
    always_comb begin
        load_data = 32'h0000_0000;
        case (load_funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LW:   load_data = word_in;
            F3_LBU:  load_data = {24'h00_0000, byte_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Replace the store lane(s), keep the remaining lanes from memory
    always_comb begin
        merged_word = word_in;
        case (store_funct2)
            F2_SB: begin
                case (byte_offset)
                    2'b00:   merged_word[7:0]   = store_data[7:0];
                    2'b01:   merged_word[15:8]  = store_data[7:0];
                    2'b10:   merged_word[23:16] = store_data[7:0];
                    2'b11:   merged_word[31:24] = store_data[7:0];
                    default: merged_word = word_in;
                endcase
            end
            F2_SH: begin
                if (byte_offset[1]) begin
                    merged_word[31:16] = store_data[15:0];
                end else begin
                    merged_word[15:0] = store_data[15:0];
                end
            end
            F2_SW:   merged_word = store_data;
            default: merged_word = word_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MA-stage initiator between the pipeline and a word-only data memory.
// Loads and SW become one word access; SB/SH become read-modify-write.
//   clock, reset    single clock, synchronous active-high reset
//   cpu_read        {en, funct3} load request
//   cpu_write       {en, funct3[1:0]} store request
//   cpu_address     byte address
//   cpu_writedata   store data
//   cpu_readdata    extended load result, valid in DONE (0 for stores/faults)
//   cpu_busywait    pipeline stall request
//   cpu_fault       one-cycle pulse in DONE on misalign/illegal/timeout
//   bus             memory bus (master side), all outputs registered
// TIMEOUT_CYCLES bounds consecutive busywait cycles per access; 0 disables it.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  cpu_read,
    input  logic [2:0]  cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_busywait,
    output logic        cpu_fault,
    mau_if.master       bus
);

    localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 32'd0) ? 32'd0
                                       : 32'(TIMEOUT_CYCLES - 32'd1);

    mau_state_e  state_r;
    logic        req_load_r;
    logic [2:0]  req_f3_r;       // store requests keep {1'b0, funct2} here
    logic [1:0]  req_off_r;
    logic [31:0] req_wdata_r;
    logic [31:0] tmo_cnt_r;
    logic [31:0] cpu_readdata_r;
    logic        cpu_fault_r;
    logic [3:0]  mem_read_r;
    logic [2:0]  mem_write_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_writedata_r;

    logic        req_active_s;
    logic        req_fault_s;
    logic        timeout_hit_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_word_s;

    assign req_active_s = cpu_read[3] | cpu_write[2];
    assign req_fault_s  = req_fault(cpu_read, cpu_write, cpu_address[1:0]);

    load_store_align u_align (
        .load_funct3  (req_f3_r),
        .store_funct2 (req_f3_r[1:0]),
        .byte_offset  (req_off_r),
        .word_in      (bus.mem_readdata),
        .store_data   (req_wdata_r),
        .load_data    (load_data_s),
        .merged_word  (merged_word_s)
    );

    // Stall: in IDLE the pipeline must stop in the same cycle it raises a request
    always_comb begin
        cpu_busywait = 1'b0;
        case (state_r)
            ST_IDLE: cpu_busywait = req_active_s;
            ST_RD:   cpu_busywait = 1'b1;
            ST_WR:   cpu_busywait = 1'b1;
            ST_DONE: cpu_busywait = 1'b0;
            default: cpu_busywait = 1'b0;
        endcase
    end

    // Timeout fires on the last allowed busywait cycle of the current phase
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TMO_EN && bus.mem_busywait && (tmo_cnt_r == TMO_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Access FSM with registered memory strobes and pipeline results
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            req_load_r      <= 1'b0;
            req_f3_r        <= 3'b000;
            req_off_r       <= 2'b00;
            req_wdata_r     <= 32'h0000_0000;
            tmo_cnt_r       <= 32'h0000_0000;
            cpu_readdata_r  <= 32'h0000_0000;
            cpu_fault_r     <= 1'b0;
            mem_read_r      <= 4'b0000;
            mem_write_r     <= 3'b000;
            mem_address_r   <= 32'h0000_0000;
            mem_writedata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_active_s) begin
                        req_load_r  <= cpu_read[3];
                        req_f3_r    <= cpu_read[3] ? cpu_read[2:0] : {1'b0, cpu_write[1:0]};
                        req_off_r   <= cpu_address[1:0];
                        req_wdata_r <= cpu_writedata;
                        tmo_cnt_r   <= 32'h0000_0000;
                        if (req_fault_s) begin
                            state_r        <= ST_DONE;
                            cpu_fault_r    <= 1'b1;
                            cpu_readdata_r <= 32'h0000_0000;
                        end else if (cpu_read[3] || (cpu_write[1:0] != F2_SW)) begin
                            // loads and sub-word stores both start with a word read
                            state_r       <= ST_RD;
                            mem_read_r    <= MEM_WORD_RD;
                            mem_address_r <= {cpu_address[31:2], 2'b00};
                        end else begin
                            state_r         <= ST_WR;
                            mem_write_r     <= MEM_WORD_WR;
                            mem_address_r   <= {cpu_address[31:2], 2'b00};
                            mem_writedata_r <= cpu_writedata;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (!bus.mem_busywait) begin
                        tmo_cnt_r  <= 32'h0000_0000;
                        mem_read_r <= 4'b0000;
                        if (req_load_r) begin
                            state_r        <= ST_DONE;
                            cpu_readdata_r <= load_data_s;
                            cpu_fault_r    <= 1'b0;
                        end else begin
                            state_r         <= ST_WR;
                            mem_write_r     <= MEM_WORD_WR;
                            mem_writedata_r <= merged_word_s;
                        end
                    end else if (timeout_hit_s) begin
                        state_r        <= ST_DONE;
                        tmo_cnt_r      <= 32'h0000_0000;
                        mem_read_r     <= 4'b0000;
                        cpu_fault_r    <= 1'b1;
                        cpu_readdata_r <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    end
                end
                ST_WR: begin
                    if (!bus.mem_busywait) begin
                        state_r        <= ST_DONE;
                        tmo_cnt_r      <= 32'h0000_0000;
                        mem_write_r    <= 3'b000;
                        cpu_readdata_r <= 32'h0000_0000;
                        cpu_fault_r    <= 1'b0;
                    end else if (timeout_hit_s) begin
                        // write strobe drops without acceptance: store not committed
                        state_r        <= ST_DONE;
                        tmo_cnt_r      <= 32'h0000_0000;
                        mem_write_r    <= 3'b000;
                        cpu_fault_r    <= 1'b1;
                        cpu_readdata_r <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    end
                end
                ST_DONE: begin
                    // pipeline advances on this edge; never re-trigger the same request
                    state_r     <= ST_IDLE;
                    cpu_fault_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cpu_fault_r <= 1'b0;
                    mem_read_r  <= 4'b0000;
                    mem_write_r <= 3'b000;
                end
            endcase
        end
    end

    assign cpu_readdata      = cpu_readdata_r;
    assign cpu_fault         = cpu_fault_r;
    assign bus.mem_read      = mem_read_r;
    assign bus.mem_write     = mem_write_r;
    assign bus.mem_address   = mem_address_r;
    assign bus.mem_writedata = mem_writedata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Two instances: u_dut (default timeout) against a word memory with a
// configurable number of busywait cycles, and u_dut_tmo (TIMEOUT_CYCLES=4)
// against a memory whose busywait is stuck high.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  cpu_read;
    logic [2:0]  cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_writedata;
    logic        use2;

    logic [3:0]  cpu_read1,  cpu_read2;
    logic [2:0]  cpu_write1, cpu_write2;
    logic [31:0] cpu_readdata1, cpu_readdata2;
    logic        cpu_busywait1, cpu_busywait2;
    logic        cpu_fault1, cpu_fault2;

    int n_checks;
    int n_fail;

    mau_if bus1();
    mau_if bus2();

    assign cpu_read1  = use2 ? 4'h0 : cpu_read;
    assign cpu_write1 = use2 ? 3'h0 : cpu_write;
    assign cpu_read2  = use2 ? cpu_read  : 4'h0;
    assign cpu_write2 = use2 ? cpu_write : 3'h0;

    mem_access_unit #(.TIMEOUT_CYCLES(256)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read1),
        .cpu_write     (cpu_write1),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata1),
        .cpu_busywait  (cpu_busywait1),
        .cpu_fault     (cpu_fault1),
        .bus           (bus1)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut_tmo (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read2),
        .cpu_write     (cpu_write2),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata2),
        .cpu_busywait  (cpu_busywait2),
        .cpu_fault     (cpu_fault2),
        .bus           (bus2)
    );

    always #5 clock = ~clock;

    // Memory 1: 16 words, word 0x10 = 0x8899AABB after reset
    logic [31:0] mem1 [0:15];
    int          wait_cfg;
    int          wait_cnt;
    int          rd_acc;
    int          wr_acc;
    int          strobe_cyc;
    logic [31:0] last_wdata;
    logic        strobe1;

    assign strobe1            = bus1.mem_read[3] | bus1.mem_write[2];
    assign bus1.mem_readdata  = mem1[bus1.mem_address[5:2]];
    assign bus1.mem_busywait  = strobe1 && (wait_cnt < wait_cfg);

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 32'h0000_0000;
            mem1[4]    <= 32'h8899_AABB;
            wait_cnt   <= 0;
            rd_acc     <= 0;
            wr_acc     <= 0;
            strobe_cyc <= 0;
            last_wdata <= 32'h0000_0000;
        end else if (strobe1) begin
            strobe_cyc <= strobe_cyc + 1;
            if (bus1.mem_busywait) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
                if (bus1.mem_read[3]) rd_acc <= rd_acc + 1;
                if (bus1.mem_write[2]) begin
                    wr_acc     <= wr_acc + 1;
                    mem1[bus1.mem_address[5:2]] <= bus1.mem_writedata;
                    last_wdata <= bus1.mem_writedata;
                end
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // Memory 2: never ready
    logic [31:0] mem2_word;
    assign bus2.mem_readdata = 32'h0000_0000;
    assign bus2.mem_busywait = 1'b1;

    always @(posedge clock) begin
        if (reset) begin
            mem2_word <= 32'h8899_AABB;
        end else if (bus2.mem_write[2] && !bus2.mem_busywait) begin
            mem2_word <= bus2.mem_writedata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and hold it until the unit drops cpu_busywait.
    // busy = number of cycles cpu_busywait was high (latency = busy + 1).
    task automatic run_access(input bit sel, input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output int busy, output logic [31:0] rdata, output logic fault);
        bit done;
        busy  = 0;
        done  = 1'b0;
        rdata = 32'h0;
        fault = 1'b0;
        @(posedge clock); #1;
        use2          = sel;
        cpu_read      = rd;
        cpu_write     = wr;
        cpu_address   = addr;
        cpu_writedata = wdata;
        while (!done) begin
            @(negedge clock);
            if (sel ? cpu_busywait2 : cpu_busywait1) begin
                busy++;
                if (busy > 64) begin
                    check_eq("access_bound", 32'(busy), 32'd64);
                    done = 1'b1;
                end
            end else begin
                rdata = sel ? cpu_readdata2 : cpu_readdata1;
                fault = sel ? cpu_fault2 : cpu_fault1;
                done  = 1'b1;
            end
        end
        @(posedge clock); #1;
        cpu_read  = 4'h0;
        cpu_write = 3'h0;
    endtask

    task automatic load_test(input string tag, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp);
        int          busy;
        logic [31:0] rdata;
        logic        fault;
        run_access(1'b0, {1'b1, f3}, 3'h0, addr, 32'h0, busy, rdata, fault);
        check_eq({tag, "_data"}, rdata, exp);
        check_eq({tag, "_busy"}, 32'(busy), 32'd2);
        check_eq({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic fault_test(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr);
        int          busy;
        logic [31:0] rdata;
        logic        fault;
        int          strobes0;
        strobes0 = strobe_cyc;
        run_access(1'b0, rd, wr, addr, 32'hFFFF_FFFF, busy, rdata, fault);
        check_eq({tag, "_fault"}, 32'(fault), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_strobes"}, 32'(strobe_cyc - strobes0), 32'd0);
        check_eq({tag, "_data"}, rdata, 32'h0);
        check_eq({tag, "_pulse"}, 32'(cpu_fault1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          busy;
        logic [31:0] rdata;
        logic        fault;
        int          rd0, wr0;

        n_checks      = 0;
        n_fail        = 0;
        clock         = 1'b0;
        reset         = 1'b1;
        use2          = 1'b0;
        cpu_read      = 4'h0;
        cpu_write     = 3'h0;
        cpu_address   = 32'h0;
        cpu_writedata = 32'h0;
        wait_cfg      = 0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busywait", 32'(cpu_busywait1), 32'd0);
        check_eq("rst_fault", 32'(cpu_fault1), 32'd0);
        check_eq("rst_readdata", cpu_readdata1, 32'h0);
        check_eq("rst_mem_read", 32'(bus1.mem_read), 32'h0);
        check_eq("rst_mem_write", 32'(bus1.mem_write), 32'h0);
        check_eq("rst_mem_address", bus1.mem_address, 32'h0);
        check_eq("rst_mem_writedata", bus1.mem_writedata, 32'h0);
        reset = 1'b0;

        // loads from word 0x10 = 0x8899AABB
        load_test("lb_11",  3'b000, 32'h11, 32'hFFFF_FFAA);
        load_test("lhu_12", 3'b101, 32'h12, 32'h0000_8899);
        load_test("lw_10",  3'b010, 32'h10, 32'h8899_AABB);
        load_test("lh_12",  3'b001, 32'h12, 32'hFFFF_8899);
        load_test("lbu_10", 3'b100, 32'h10, 32'h0000_00BB);
        load_test("lb_13",  3'b000, 32'h13, 32'hFFFF_FF88);
        load_test("lh_10",  3'b001, 32'h10, 32'hFFFF_AABB);

        // SB: read-modify-write, 4-cycle latency
        rd0 = rd_acc;
        wr0 = wr_acc;
        run_access(1'b0, 4'h0, 3'b100, 32'h13, 32'h0000_0055, busy, rdata, fault);
        check_eq("sb_busy", 32'(busy), 32'd3);
        check_eq("sb_data", rdata, 32'h0);
        check_eq("sb_fault", 32'(fault), 32'd0);
        check_eq("sb_reads", 32'(rd_acc - rd0), 32'd1);
        check_eq("sb_writes", 32'(wr_acc - wr0), 32'd1);
        check_eq("sb_wdata", last_wdata, 32'h5599_AABB);

        // SW with 5 busywait cycles: DONE on the 8th cycle
        wait_cfg = 5;
        run_access(1'b0, 4'h0, 3'b110, 32'h10, 32'hDEAD_BEEF, busy, rdata, fault);
        check_eq("sw_wait_busy", 32'(busy), 32'd7);
        check_eq("sw_wait_fault", 32'(fault), 32'd0);
        wait_cfg = 0;
        load_test("lw_after_sw", 3'b010, 32'h10, 32'hDEAD_BEEF);

        // SH upper half
        run_access(1'b0, 4'h0, 3'b101, 32'h12, 32'hCAFE_1234, busy, rdata, fault);
        check_eq("sh_busy", 32'(busy), 32'd3);
        check_eq("sh_wdata", last_wdata, 32'h1234_BEEF);
        load_test("lw_after_sh", 3'b010, 32'h10, 32'h1234_BEEF);

        // requests that must fault without a memory strobe
        fault_test("lw_06",     4'b1010, 3'b000, 32'h06);
        fault_test("sh_11",     4'b0000, 3'b101, 32'h11);
        fault_test("ld_f3_011", 4'b1011, 3'b000, 32'h10);
        fault_test("st_f2_11",  4'b0000, 3'b111, 32'h10);
        fault_test("both_en",   4'b1000, 3'b100, 32'h10);

        // reset while waiting in RD
        wait_cfg = 20;
        @(posedge clock); #1;
        cpu_read    = 4'b1010;
        cpu_address = 32'h10;
        @(posedge clock); #1;
        check_eq("rd_mem_read", 32'(bus1.mem_read), 32'hA);
        check_eq("rd_busywait", 32'(cpu_busywait1), 32'd1);
        reset    = 1'b1;
        cpu_read = 4'h0;
        @(posedge clock); #1;
        check_eq("abort_mem_read", 32'(bus1.mem_read), 32'h0);
        check_eq("abort_mem_write", 32'(bus1.mem_write), 32'h0);
        check_eq("abort_busywait", 32'(cpu_busywait1), 32'd0);
        check_eq("abort_mem_address", bus1.mem_address, 32'h0);
        reset    = 1'b0;
        wait_cfg = 0;
        load_test("lw_after_abort", 3'b010, 32'h10, 32'h8899_AABB);

        // timeout instance: memory never ready
        run_access(1'b1, 4'h0, 3'b110, 32'h10, 32'h1122_3344, busy, rdata, fault);
        check_eq("tmo_sw_busy", 32'(busy), 32'd5);
        check_eq("tmo_sw_fault", 32'(fault), 32'd1);
        check_eq("tmo_sw_data", rdata, 32'h0);
        check_eq("tmo_sw_mem", mem2_word, 32'h8899_AABB);
        check_eq("tmo_mem_write", 32'(bus2.mem_write), 32'h0);
        run_access(1'b1, 4'b1000, 3'h0, 32'h11, 32'h0, busy, rdata, fault);
        check_eq("tmo_lb_busy", 32'(busy), 32'd5);
        check_eq("tmo_lb_fault", 32'(fault), 32'd1);
        check_eq("tmo_lb_pulse", 32'(cpu_fault2), 32'd0);
        use2 = 1'b0;

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
